// File: rtl/memory_pipelined_rw.sv
// Simple-dual-port memory with masked writes, configurable read latency and
// selectable read-during-write behaviour; only the read pipeline is reset.
module memory_pipelined_rw #(
  parameter int WIDTH        = 5,
  parameter int DEPTH        = 4,
  parameter int READ_LATENCY = 2,
  parameter int RDW_NEW_DATA = 0,
  localparam int ADDR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESETN,
  input  logic [ADDR_WIDTH-1:0] WADDR,
  input  logic [WIDTH-1:0]      WDATA,
  input  logic [WIDTH-1:0]      WMASK,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] RADDR,
  input  logic                  RE,
  output logic [WIDTH-1:0]      RDATA,
  output logic                  RVALID
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [WIDTH-1:0]        data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_q;

  logic             wr_in_range;
  logic             rd_in_range;
  logic [WIDTH-1:0] wr_merged_d;
  logic [WIDTH-1:0] rd_word_d;

  assign wr_in_range = ({1'b0, WADDR} < DEPTH_W);
  assign rd_in_range = ({1'b0, RADDR} < DEPTH_W);

  always_comb begin
    wr_merged_d = '0;
    rd_word_d   = '0;
    if (wr_in_range) begin
      wr_merged_d = (mem_q[WADDR] & ~WMASK) | (WDATA & WMASK);
    end
    // Out-of-range reads are still accepted; they simply return zero.
    if (rd_in_range) begin
      if ((RDW_NEW_DATA != 0) && WE && wr_in_range && (WADDR == RADDR)) begin
        rd_word_d = wr_merged_d;
      end else begin
        rd_word_d = mem_q[RADDR];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (ASYNCRESETN && WE && wr_in_range) begin
      mem_q[WADDR] <= wr_merged_d;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= RE;
      if (RE) begin
        data_q[0] <= rd_word_d;
      end
      // Data only moves with a valid token so RDATA holds the last read.
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign RDATA  = data_q[READ_LATENCY-1];
  assign RVALID = vld_q[READ_LATENCY-1];

endmodule
